// File: rtl/ct_ifu_vector_gen2_if.sv
// ---------------------------------------------------------------------------
// ct_ifu_vector_gen2_if
// Signal bundle between the IFU vector unit and its RTU/CP0 requesters and
// pcgen/ifctrl consumers. Clock and reset are not part of the bundle.
//
// Modports
//   master : RTU/CP0 side. Drives reset type, debug, trap request/vector,
//            trap/reset bases and invalidate-done. Observes all unit outputs.
//   slave  : the vector unit itself (ct_ifu_vector_gen2).
//
// Signals (direction as seen by the vector unit)
//   arch_rst_b             in   1 = micro-architectural reset only
//   rtu_ifu_xx_dbgon       in   debug mode on
//   rtu_ifu_xx_expt_vld    in   trap redirect request
//   rtu_ifu_xx_expt_vec    in   {int, cause}
//   cp0_ifu_vbr            in   trap base; bit0 = vectored mode
//   cp0_ifu_rvbr           in   reset base
//   cp0_ifu_rst_inv_done   in   icache invalidate complete
//   ifu_cp0_rst_inv_req    out  invalidate request pulse
//   ifu_cp0_rst_mrvbr_req  out  mrvbr reload pulse
//   ifu_xx_sync_reset      out  high in RESET/URESET
//   vector_pcgen_pcload    out  load vector_pcgen_pc
//   vector_pcgen_pc        out  redirect PC, halfword granular
//   vector_ifctrl_sm_on    out  state machine not idle
//   vector_inv_timeout_err out  sticky: invalidate retries exhausted
//   vector_debug_cur_st    out  encoded state
//
// Optional macro CT_IFU_VECTOR_NMI_EN adds rtu_ifu_xx_nmi_vld and
// cp0_ifu_nmivbr (both inputs to the vector unit).
// ---------------------------------------------------------------------------
interface ct_ifu_vector_gen2_if #(
   parameter int PC_WIDTH = 40,
   parameter int CAUSE_W  = 6
);
   logic                arch_rst_b;
   logic                rtu_ifu_xx_dbgon;
   logic                rtu_ifu_xx_expt_vld;
   logic [CAUSE_W-1:0]  rtu_ifu_xx_expt_vec;
   logic [PC_WIDTH-1:0] cp0_ifu_vbr;
   logic [PC_WIDTH-1:0] cp0_ifu_rvbr;
   logic                cp0_ifu_rst_inv_done;
`ifdef CT_IFU_VECTOR_NMI_EN
   logic                rtu_ifu_xx_nmi_vld;
   logic [PC_WIDTH-1:0] cp0_ifu_nmivbr;
`endif
   logic                ifu_cp0_rst_inv_req;
   logic                ifu_cp0_rst_mrvbr_req;
   logic                ifu_xx_sync_reset;
   logic                vector_pcgen_pcload;
   logic [PC_WIDTH-2:0] vector_pcgen_pc;
   logic                vector_ifctrl_sm_on;
   logic                vector_inv_timeout_err;
   logic [2:0]          vector_debug_cur_st;

   modport master (
      output arch_rst_b, rtu_ifu_xx_dbgon, rtu_ifu_xx_expt_vld, rtu_ifu_xx_expt_vec,
             cp0_ifu_vbr, cp0_ifu_rvbr, cp0_ifu_rst_inv_done,
`ifdef CT_IFU_VECTOR_NMI_EN
             rtu_ifu_xx_nmi_vld, cp0_ifu_nmivbr,
`endif
      input  ifu_cp0_rst_inv_req, ifu_cp0_rst_mrvbr_req, ifu_xx_sync_reset,
             vector_pcgen_pcload, vector_pcgen_pc, vector_ifctrl_sm_on,
             vector_inv_timeout_err, vector_debug_cur_st
   );

   modport slave (
      input  arch_rst_b, rtu_ifu_xx_dbgon, rtu_ifu_xx_expt_vld, rtu_ifu_xx_expt_vec,
             cp0_ifu_vbr, cp0_ifu_rvbr, cp0_ifu_rst_inv_done,
`ifdef CT_IFU_VECTOR_NMI_EN
             rtu_ifu_xx_nmi_vld, cp0_ifu_nmivbr,
`endif
      output ifu_cp0_rst_inv_req, ifu_cp0_rst_mrvbr_req, ifu_xx_sync_reset,
             vector_pcgen_pcload, vector_pcgen_pc, vector_ifctrl_sm_on,
             vector_inv_timeout_err, vector_debug_cur_st
   );
endinterface

// File: rtl/ct_ifu_vector_gen2.sv
// ---------------------------------------------------------------------------
// ct_ifu_vector_gen2
// IFU vector unit. Sequences reset entry through an icache-invalidate
// handshake (timeout + bounded retry) and produces trap / reset redirect PCs
// for pcgen, with back-to-back trap redirects handled without an idle bubble.
//
// Ports
//   forever_cpuclk : clock
//   cpurst         : asynchronous active-high reset
//   vif            : ct_ifu_vector_gen2_if.slave (requests in, redirect out)
//
// Parameters
//   PC_WIDTH        byte-address width; output PC is PC_WIDTH-1 bits
//   CAUSE_W         exception vector width, MSB = interrupt flag
//   VEC_STRIDE_LOG2 log2 byte stride between vectored entries (1..6)
//   INV_TIMEOUT     cycles waited for invalidate done before reissue (>=2)
//   MAX_RETRY       reissues before giving up and flagging the error
//
// Optional feature: define CT_IFU_VECTOR_NMI_EN to add NMI redirect support
// (NMI beats a same-cycle trap; NMIs seen during reset are held pending and
// taken on the first idle cycle).
// ---------------------------------------------------------------------------
module ct_ifu_vector_gen2 #(
   parameter int PC_WIDTH        = 40,
   parameter int CAUSE_W         = 6,
   parameter int VEC_STRIDE_LOG2 = 2,
   parameter int INV_TIMEOUT     = 1024,
   parameter int MAX_RETRY       = 3
) (
   input  logic               forever_cpuclk,
   input  logic               cpurst,
   ct_ifu_vector_gen2_if.slave vif
);

   localparam int CNT_W = $clog2(INV_TIMEOUT);
   localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INV_TIMEOUT - 1);
   localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      PRE_RESET = 3'd1,
      RESET     = 3'd2,
      URESET    = 3'd3,
      PCLOAD    = 3'd4
   } state_t;

   state_t              state_reg, state_next;
   logic [CNT_W-1:0]    cnt_reg, cnt_next;
   logic [RTY_W-1:0]    retry_reg, retry_next;
   logic                err_reg, err_next;
   logic [PC_WIDTH-2:0] pc_reg, pc_next;

   logic                pcload;
   logic                inv_req;
   logic                mrvbr_req;
   logic                in_rst;
   logic                timeout;

   // ---------------- redirect PC computation ----------------
   logic                int_flag;
   logic [CAUSE_W-2:0]  cause;
   logic                reset_expt;
   logic [PC_WIDTH-2:0] rvbr_pc;
   logic [PC_WIDTH-2:0] trap_base;
   logic [PC_WIDTH-2:0] vec_offset;
   logic [PC_WIDTH-2:0] expt_pc;

   assign int_flag   = vif.rtu_ifu_xx_expt_vec[CAUSE_W-1];
   assign cause      = vif.rtu_ifu_xx_expt_vec[CAUSE_W-2:0];
   assign reset_expt = (cause == '0) && !int_flag;
   assign rvbr_pc    = vif.cp0_ifu_rvbr[PC_WIDTH-1:1];
   // vbr bit0 is the mode flag and bit1 is ignored, so both drop out of the base
   assign trap_base  = {vif.cp0_ifu_vbr[PC_WIDTH-1:2], 1'b0};
   // Halfword PC: a byte stride of 2^VEC_STRIDE_LOG2 is a shift of LOG2-1
   assign vec_offset = {{(PC_WIDTH-CAUSE_W){1'b0}}, cause} << (VEC_STRIDE_LOG2 - 1);
   assign expt_pc    = reset_expt                          ? rvbr_pc :
                       (vif.cp0_ifu_vbr[0] && int_flag)    ? trap_base + vec_offset :
                                                             trap_base;

`ifdef CT_IFU_VECTOR_NMI_EN
   logic                pend_reg, pend_next;
   logic                nmi_take;
   logic [PC_WIDTH-2:0] nmi_pc;
   logic                unused_nmi_bit;

   assign nmi_take       = vif.rtu_ifu_xx_nmi_vld || pend_reg;
   assign nmi_pc         = vif.cp0_ifu_nmivbr[PC_WIDTH-1:1];
   assign unused_nmi_bit = vif.cp0_ifu_nmivbr[0];
`endif

   logic unused_bits;
   assign unused_bits = ^{vif.cp0_ifu_vbr[1], vif.cp0_ifu_rvbr[0]};

   assign in_rst  = (state_reg == RESET) || (state_reg == URESET);
   // Done on the expiry cycle takes precedence, so timeout excludes it
   assign timeout = (cnt_reg == CNT_LAST) && !vif.cp0_ifu_rst_inv_done;

   // ---------------- next-state / output logic ----------------
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      retry_next = retry_reg;
      err_next   = err_reg;
      pc_next    = pc_reg;
      pcload     = 1'b0;
      inv_req    = 1'b0;
      mrvbr_req  = 1'b0;
`ifdef CT_IFU_VECTOR_NMI_EN
      pend_next  = pend_reg;
`endif

      case (state_reg)
         PRE_RESET: begin
            state_next = vif.arch_rst_b ? URESET : RESET;
            cnt_next   = '0;
            retry_next = '0;
            // Preload so pc is already valid on the first handshake cycle
            pc_next    = rvbr_pc;
         end

         RESET, URESET: begin
            pc_next   = rvbr_pc;
            // Counter sits at zero exactly on entry and right after each
            // timeout, which are precisely the request cycles
            inv_req   = (cnt_reg == '0);
            mrvbr_req = (cnt_reg == '0) && (retry_reg == '0) && (state_reg == RESET);
            if (vif.cp0_ifu_rst_inv_done) begin
               pcload     = 1'b1;
               state_next = IDLE;
               cnt_next   = '0;
               retry_next = '0;
            end else if (timeout) begin
               cnt_next = '0;
               if (retry_reg < RTY_MAX) begin
                  retry_next = retry_reg + 1'b1;
               end else begin
                  err_next   = 1'b1;
                  pcload     = 1'b1;
                  state_next = IDLE;
                  retry_next = '0;
               end
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end

         IDLE, PCLOAD: begin
            pcload     = (state_reg == PCLOAD);
            state_next = IDLE;
`ifdef CT_IFU_VECTOR_NMI_EN
            if (nmi_take) begin
               pc_next    = nmi_pc;
               state_next = PCLOAD;
               pend_next  = 1'b0;
            end else
`endif
            if (vif.rtu_ifu_xx_expt_vld) begin
               pc_next    = expt_pc;
               state_next = PCLOAD;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase

`ifdef CT_IFU_VECTOR_NMI_EN
      if ((in_rst || (state_reg == PRE_RESET)) && vif.rtu_ifu_xx_nmi_vld) begin
         pend_next = 1'b1;
      end
      if (vif.rtu_ifu_xx_dbgon) begin
         pend_next = 1'b0;
      end
`endif

      // Debug mode overrides everything except the reset-type sampling step
      if (vif.rtu_ifu_xx_dbgon) begin
         pcload    = 1'b0;
         inv_req   = 1'b0;
         mrvbr_req = 1'b0;
         if (state_reg != PRE_RESET) begin
            state_next = IDLE;
            cnt_next   = '0;
            retry_next = '0;
            err_next   = err_reg;
            pc_next    = pc_reg;
         end
      end
   end

   // ---------------- state registers ----------------
   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst) begin
         state_reg <= PRE_RESET;
         cnt_reg   <= '0;
         retry_reg <= '0;
         err_reg   <= 1'b0;
         pc_reg    <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         retry_reg <= retry_next;
         err_reg   <= err_next;
         pc_reg    <= pc_next;
      end
   end

`ifdef CT_IFU_VECTOR_NMI_EN
   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst) begin
         pend_reg <= 1'b0;
      end else begin
         pend_reg <= pend_next;
      end
   end
`endif

   // ---------------- outputs ----------------
   assign vif.ifu_cp0_rst_inv_req    = inv_req;
   assign vif.ifu_cp0_rst_mrvbr_req  = mrvbr_req;
   assign vif.ifu_xx_sync_reset      = in_rst;
   assign vif.vector_pcgen_pcload    = pcload;
   assign vif.vector_pcgen_pc        = pc_reg;
   assign vif.vector_ifctrl_sm_on    = (state_reg != IDLE);
   assign vif.vector_inv_timeout_err = err_reg;
   assign vif.vector_debug_cur_st    = state_reg;

endmodule

// File: tb/tb_ct_ifu_vector_gen2.sv
// ---------------------------------------------------------------------------
// tb_ct_ifu_vector_gen2
// Directed bench for ct_ifu_vector_gen2 with PC_WIDTH=40, VEC_STRIDE_LOG2=2,
// INV_TIMEOUT=16, MAX_RETRY=2. Inputs change 1 time unit after the rising
// edge; outputs are compared on the falling edge.
// ---------------------------------------------------------------------------
module tb_ct_ifu_vector_gen2;
   localparam int PC_WIDTH        = 40;
   localparam int CAUSE_W         = 6;
   localparam int VEC_STRIDE_LOG2 = 2;
   localparam int INV_TIMEOUT     = 16;
   localparam int MAX_RETRY       = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ct_ifu_vector_gen2_if #(.PC_WIDTH(PC_WIDTH), .CAUSE_W(CAUSE_W)) bus ();

   ct_ifu_vector_gen2 #(
      .PC_WIDTH       (PC_WIDTH),
      .CAUSE_W        (CAUSE_W),
      .VEC_STRIDE_LOG2(VEC_STRIDE_LOG2),
      .INV_TIMEOUT    (INV_TIMEOUT),
      .MAX_RETRY      (MAX_RETRY)
   ) dut (
      .forever_cpuclk(clk),
      .cpurst        (rst),
      .vif           (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   // Assert reset, check the reset values, release, pass PRE_RESET.
   // Returns just after the edge that starts the first RESET/URESET cycle.
   task automatic enter_reset(input logic arch);
      next_cyc();
      rst = 1'b1;
      bus.arch_rst_b           = arch;
      bus.rtu_ifu_xx_dbgon     = 1'b0;
      bus.rtu_ifu_xx_expt_vld  = 1'b0;
      bus.cp0_ifu_rst_inv_done = 1'b0;
`ifdef CT_IFU_VECTOR_NMI_EN
      bus.rtu_ifu_xx_nmi_vld   = 1'b0;
`endif
      @(negedge clk);
      check("rst_state",  bus.vector_debug_cur_st, 1);
      check("rst_sm_on",  bus.vector_ifctrl_sm_on, 1);
      check("rst_pc",     bus.vector_pcgen_pc, 0);
      check("rst_err",    bus.vector_inv_timeout_err, 0);
      check("rst_pcload", bus.vector_pcgen_pcload, 0);
      check("rst_inv",    bus.ifu_cp0_rst_inv_req, 0);
      check("rst_mrvbr",  bus.ifu_cp0_rst_mrvbr_req, 0);
      check("rst_sync",   bus.ifu_xx_sync_reset, 0);
      next_cyc();
      rst = 1'b0;
      @(negedge clk);
      check("pre_state", bus.vector_debug_cur_st, 1);
      next_cyc();
      $display("reset entered arch_rst_b=%0b rvbr=0x%010h", arch, bus.cp0_ifu_rvbr);
   endtask

   // One IDLE trap request followed by its PCLOAD cycle and return to IDLE.
   task automatic trap(input string tag, input logic [39:0] vbr, input logic [5:0] vec,
                       input logic [38:0] exp_pc);
      next_cyc();
      bus.cp0_ifu_vbr         = vbr;
      bus.rtu_ifu_xx_expt_vec = vec;
      bus.rtu_ifu_xx_expt_vld = 1'b1;
      @(negedge clk);
      check({tag, "_req_pcload"}, bus.vector_pcgen_pcload, 0);
      next_cyc();
      bus.rtu_ifu_xx_expt_vld = 1'b0;
      @(negedge clk);
      check({tag, "_pcload"}, bus.vector_pcgen_pcload, 1);
      check({tag, "_pc"},     bus.vector_pcgen_pc, exp_pc);
      check({tag, "_state"},  bus.vector_debug_cur_st, 4);
      $display("trap %s vbr=0x%010h vec=%b pc=0x%010h", tag, vbr, vec, bus.vector_pcgen_pc);
      next_cyc();
      @(negedge clk);
      check({tag, "_idle"}, bus.vector_debug_cur_st, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.arch_rst_b           = 1'b0;
      bus.rtu_ifu_xx_dbgon     = 1'b0;
      bus.rtu_ifu_xx_expt_vld  = 1'b0;
      bus.rtu_ifu_xx_expt_vec  = '0;
      bus.cp0_ifu_vbr          = '0;
      bus.cp0_ifu_rvbr         = '0;
      bus.cp0_ifu_rst_inv_done = 1'b0;
`ifdef CT_IFU_VECTOR_NMI_EN
      bus.rtu_ifu_xx_nmi_vld   = 1'b0;
      bus.cp0_ifu_nmivbr       = '0;
`endif

      // 1: full reset, done 5 cycles after the request
      bus.cp0_ifu_rvbr = 40'h0080000000;
      enter_reset(1'b0);
      for (int k = 0; k <= 5; k++) begin
         if (k == 5) bus.cp0_ifu_rst_inv_done = 1'b1;
         @(negedge clk);
         if (k == 0) begin
            check("t1_state", bus.vector_debug_cur_st, 2);
            check("t1_sync",  bus.ifu_xx_sync_reset, 1);
         end
         check("t1_inv",    bus.ifu_cp0_rst_inv_req,   (k == 0));
         check("t1_mrvbr",  bus.ifu_cp0_rst_mrvbr_req, (k == 0));
         check("t1_pcload", bus.vector_pcgen_pcload,   (k == 5));
         if (k == 5) check("t1_pc", bus.vector_pcgen_pc, 39'h0040000000);
         if (k < 5) next_cyc();
      end
      next_cyc();
      bus.cp0_ifu_rst_inv_done = 1'b0;
      @(negedge clk);
      check("t1_idle",  bus.vector_debug_cur_st, 0);
      check("t1_err",   bus.vector_inv_timeout_err, 0);
      check("t1_sm_on", bus.vector_ifctrl_sm_on, 0);

      // 2: micro-arch reset, done never arrives -> two retries then error
      bus.cp0_ifu_rvbr = 40'h0123456780;
      enter_reset(1'b1);
      for (int k = 0; k <= 47; k++) begin
         @(negedge clk);
         if (k == 0) check("t2_state", bus.vector_debug_cur_st, 3);
         check("t2_inv",    bus.ifu_cp0_rst_inv_req, (k == 0 || k == 16 || k == 32));
         check("t2_mrvbr",  bus.ifu_cp0_rst_mrvbr_req, 0);
         check("t2_pcload", bus.vector_pcgen_pcload, (k == 47));
         if (k == 46) check("t2_err_pre", bus.vector_inv_timeout_err, 0);
         if (k == 47) check("t2_pc", bus.vector_pcgen_pc, 39'h0091A2B3C0);
         if (k < 47) next_cyc();
      end
      next_cyc();
      @(negedge clk);
      check("t2_idle", bus.vector_debug_cur_st, 0);
      check("t2_err",  bus.vector_inv_timeout_err, 1);

      // 3 plus PC-formation boundaries
      trap("t3_vect",   40'h0010000001, 6'b100111, 39'h000800000E);
      trap("nonvect",   40'h0000002000, 6'b100011, 39'h0000001000);
      trap("bit1_ign",  40'h0000002003, 6'b100011, 39'h0000001006);
      trap("int_c0",    40'h0000002001, 6'b100000, 39'h0000001000);
      trap("rst_expt",  40'h0000002001, 6'b000000, 39'h0091A2B3C0);
      trap("wrap",      40'hFFFFFFFFFD, 6'b111111, 39'h000000003C);

      // 4: back-to-back traps
      next_cyc();
      bus.cp0_ifu_vbr         = 40'h0000002001;
      bus.rtu_ifu_xx_expt_vld = 1'b1;
      bus.rtu_ifu_xx_expt_vec = 6'b000010;
      @(negedge clk);
      next_cyc();
      bus.rtu_ifu_xx_expt_vec = 6'b100011;
      @(negedge clk);
      check("t4_pcload1", bus.vector_pcgen_pcload, 1);
      check("t4_pc1",     bus.vector_pcgen_pc, 39'h1000);
      next_cyc();
      bus.rtu_ifu_xx_expt_vld = 1'b0;
      @(negedge clk);
      check("t4_pcload2", bus.vector_pcgen_pcload, 1);
      check("t4_pc2",     bus.vector_pcgen_pc, 39'h1006);
      $display("b2b traps pc=0x1000 then 0x%0h", bus.vector_pcgen_pc);
      next_cyc();
      @(negedge clk);
      check("t4_idle", bus.vector_debug_cur_st, 0);

      // dbgon in IDLE blocks a trap
      next_cyc();
      bus.rtu_ifu_xx_dbgon    = 1'b1;
      bus.rtu_ifu_xx_expt_vld = 1'b1;
      @(negedge clk);
      next_cyc();
      bus.rtu_ifu_xx_dbgon    = 1'b0;
      bus.rtu_ifu_xx_expt_vld = 1'b0;
      @(negedge clk);
      check("dbg_idle_state",  bus.vector_debug_cur_st, 0);
      check("dbg_idle_pcload", bus.vector_pcgen_pcload, 0);
      check("err_sticky",      bus.vector_inv_timeout_err, 1);

      // 5: dbgon with done in RESET (reset also clears err)
      enter_reset(1'b0);
      bus.rtu_ifu_xx_dbgon     = 1'b1;
      bus.cp0_ifu_rst_inv_done = 1'b1;
      @(negedge clk);
      check("t5_pcload", bus.vector_pcgen_pcload, 0);
      check("t5_inv",    bus.ifu_cp0_rst_inv_req, 0);
      check("t5_mrvbr",  bus.ifu_cp0_rst_mrvbr_req, 0);
      next_cyc();
      bus.rtu_ifu_xx_dbgon     = 1'b0;
      bus.cp0_ifu_rst_inv_done = 1'b0;
      @(negedge clk);
      check("t5_idle",   bus.vector_debug_cur_st, 0);
      check("t5_pcload2", bus.vector_pcgen_pcload, 0);

      // cpurst mid-handshake restarts counters
      enter_reset(1'b0);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("abort_inv", bus.ifu_cp0_rst_inv_req, (k == 0));
      end
      enter_reset(1'b0);
      for (int k = 0; k <= 16; k++) begin
         if (k == 16) bus.cp0_ifu_rst_inv_done = 1'b1;
         @(negedge clk);
         check("restart_inv",   bus.ifu_cp0_rst_inv_req, (k == 0 || k == 16));
         check("restart_mrvbr", bus.ifu_cp0_rst_mrvbr_req, (k == 0));
         if (k == 16) check("restart_pcload", bus.vector_pcgen_pcload, 1);
         if (k < 16) next_cyc();
      end
      next_cyc();
      bus.cp0_ifu_rst_inv_done = 1'b0;
      @(negedge clk);
      check("restart_idle", bus.vector_debug_cur_st, 0);

      // done coincides with final timeout: done wins, no error
      bus.cp0_ifu_rvbr = 40'h0123456780;
      enter_reset(1'b1);
      for (int k = 0; k <= 47; k++) begin
         if (k == 47) bus.cp0_ifu_rst_inv_done = 1'b1;
         @(negedge clk);
         check("tie_inv",    bus.ifu_cp0_rst_inv_req, (k == 0 || k == 16 || k == 32));
         check("tie_pcload", bus.vector_pcgen_pcload, (k == 47));
         if (k < 47) next_cyc();
      end
      next_cyc();
      bus.cp0_ifu_rst_inv_done = 1'b0;
      @(negedge clk);
      check("tie_idle", bus.vector_debug_cur_st, 0);
      check("tie_err",  bus.vector_inv_timeout_err, 0);

`ifdef CT_IFU_VECTOR_NMI_EN
      // 6a: NMI beats same-cycle trap
      next_cyc();
      bus.cp0_ifu_nmivbr      = 40'h0000003000;
      bus.rtu_ifu_xx_nmi_vld  = 1'b1;
      bus.rtu_ifu_xx_expt_vld = 1'b1;
      bus.cp0_ifu_vbr         = 40'h0000002001;
      bus.rtu_ifu_xx_expt_vec = 6'b100011;
      @(negedge clk);
      next_cyc();
      bus.rtu_ifu_xx_nmi_vld  = 1'b0;
      bus.rtu_ifu_xx_expt_vld = 1'b0;
      @(negedge clk);
      check("nmi_pcload", bus.vector_pcgen_pcload, 1);
      check("nmi_pc",     bus.vector_pcgen_pc, 39'h1800);
      next_cyc();
      @(negedge clk);
      check("nmi_idle", bus.vector_debug_cur_st, 0);

      // 6b: NMI during RESET is taken on the first IDLE cycle
      bus.cp0_ifu_rvbr = 40'h0080000000;
      enter_reset(1'b0);
      @(negedge clk);
      next_cyc();
      bus.rtu_ifu_xx_nmi_vld = 1'b1;
      @(negedge clk);
      next_cyc();
      bus.rtu_ifu_xx_nmi_vld = 1'b0;
      @(negedge clk);
      next_cyc();
      bus.cp0_ifu_rst_inv_done = 1'b1;
      @(negedge clk);
      check("pend_rst_pcload", bus.vector_pcgen_pcload, 1);
      check("pend_rst_pc",     bus.vector_pcgen_pc, 39'h0040000000);
      next_cyc();
      bus.cp0_ifu_rst_inv_done = 1'b0;
      @(negedge clk);
      check("pend_idle",   bus.vector_debug_cur_st, 0);
      check("pend_idle_pl", bus.vector_pcgen_pcload, 0);
      next_cyc();
      @(negedge clk);
      check("pend_state",  bus.vector_debug_cur_st, 4);
      check("pend_pcload", bus.vector_pcgen_pcload, 1);
      check("pend_pc",     bus.vector_pcgen_pc, 39'h1800);
      next_cyc();
      @(negedge clk);
      check("pend_done", bus.vector_debug_cur_st, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/ct_ifu_vector_gen2.md
Name: ct_ifu_vector_gen2

Overview:
Second-generation IFU vector unit. Sequences reset entry through an icache-invalidate handshake with timeout and retry, and computes trap and reset redirect PCs with a parametrised vector stride. Handles back-to-back exceptions without an IDLE bubble. Sits between RTU/CP0 and pcgen/ifctrl.

Parameters:
PC_WIDTH, 40, byte-address width; the PC output is halfword-granular, PC_WIDTH-1 bits.
CAUSE_W, 6, exception vector width; the MSB is the interrupt flag.
VEC_STRIDE_LOG2, 2, log2 of the byte stride between vectored-interrupt entries; legal range 1..6.
INV_TIMEOUT, 1024, cycles to wait for invalidate done before reissuing the request; must be ≥2.
MAX_RETRY, 3, number of reissues before giving up.

Ports:
forever_cpuclk  in  1  clock
cpurst  in  1  reset; asynchronous, active-high
arch_rst_b  in  1  sampled in PRE_RESET; 1 = micro-architectural reset only
rtu_ifu_xx_dbgon  in  1  debug mode on
rtu_ifu_xx_expt_vld  in  1  trap redirect request
rtu_ifu_xx_expt_vec  in  CAUSE_W  {int, cause}
cp0_ifu_vbr  in  PC_WIDTH  trap base; bit0 = vectored mode; bit1 ignored
cp0_ifu_rvbr  in  PC_WIDTH  reset base
cp0_ifu_rst_inv_done  in  1  invalidate complete
ifu_cp0_rst_inv_req  out  1  invalidate request pulse
ifu_cp0_rst_mrvbr_req  out  1  mrvbr reload pulse
ifu_xx_sync_reset  out  1  high in RESET/URESET
vector_pcgen_pcload  out  1  load vector_pcgen_pc
vector_pcgen_pc  out  PC_WIDTH-1  redirect PC (halfword)
vector_ifctrl_sm_on  out  1  state ≠ IDLE
vector_inv_timeout_err  out  1  sticky: retries exhausted
vector_debug_cur_st  out  3  encoded state

Behaviour:
- States (encoding): IDLE=0, PRE_RESET=1, RESET=2, URESET=3, PCLOAD=4.
- Values while cpurst is high: state=PRE_RESET, pc=0, err=0, timeout counter=0, retry count=0. All outputs are 0 except vector_ifctrl_sm_on=1 and vector_debug_cur_st=1.
- PRE_RESET -> URESET if arch_rst_b, else RESET. The transition takes one cycle.
- RESET/URESET, inv_req: asserted on the first cycle in the state and on the first cycle after each timeout. It is a 1-cycle pulse.
- RESET/URESET, mrvbr_req: asserted with the first inv_req only. Only in RESET, never in URESET, never on retries.
- RESET/URESET, timeout counter: clears on each inv_req and increments every other cycle in the state. When it reaches INV_TIMEOUT-1 without done:
  - if retry count < MAX_RETRY: increment retry count and reissue inv_req next cycle;
  - otherwise: set err, go to IDLE, and assert pcload in that cycle.
- RESET/URESET, done: done -> IDLE with pcload=1 the same cycle (combinational).
- RESET/URESET, pc register: tracks cp0_ifu_rvbr[PC_WIDTH-1:1] every cycle.
- RESET/URESET, expt_vld: ignored.
- Reset-vs-trap select: reset_expt = (cause==0 && !int). When reset_expt, the PC is rvbr[PC_WIDTH-1:1].
- Trap PC: base = {vbr[PC_WIDTH-1:2],1'b0}. If vbr[0] && int, PC = base + (cause << (VEC_STRIDE_LOG2-1)), truncated modulo 2^(PC_WIDTH-1). Otherwise PC = base.
- IDLE + expt_vld: capture the PC at the edge and go to PCLOAD.
- PCLOAD: pcload=1 for one cycle. If expt_vld is also high, recapture the PC and stay in PCLOAD (back-to-back). Otherwise go to IDLE.
- dbgon: forces IDLE at the next edge from any state except PRE_RESET. It also forces pcload=0, inv_req=0 and mrvbr_req=0 combinationally while asserted.
- Simultaneous timeout expiry and done: done wins; no retry, err unchanged.
- err clears only on cpurst.
- cpurst asserted mid-handshake aborts immediately to PRE_RESET and clears the counters.

Optional Feature:
CT_IFU_VECTOR_NMI_EN
- Defined: adds ports rtu_ifu_xx_nmi_vld (in, 1) and cp0_ifu_nmivbr (in, PC_WIDTH).
- In IDLE/PCLOAD, an NMI has priority over a same-cycle expt_vld: PC = nmivbr[PC_WIDTH-1:1], next state PCLOAD.
- An NMI arriving in PRE_RESET/RESET/URESET sets a pending flag. On the first IDLE cycle the pending flag acts as nmi_vld, then clears.
- dbgon clears the pending flag.
- Undefined: no ports, no logic; behaviour exactly as described above.

Test Plan:
Bench configuration for all scenarios: PC_WIDTH=40, VEC_STRIDE_LOG2=2, INV_TIMEOUT=16, MAX_RETRY=2.
1. Release cpurst; arch_rst_b=0, rvbr=0x0080000000, done pulsed 5 cycles after inv_req -> expect:
   - inv_req and mrvbr_req pulse together once;
   - pcload=1 on the done cycle with pc=0x0040000000;
   - IDLE next cycle, err=0.
2. arch_rst_b=1, done never -> expect:
   - inv_req at relative cycles 0, 16, 32;
   - mrvbr_req never;
   - at cycle 47: err=1, pcload=1, pc=rvbr>>1, state IDLE.
3. vbr=0x0010000001, expt_vec=6'b100111 -> expect pcload next cycle with pc=0x000800000E (byte 0x001000001C).
4. expt_vld at t (vec 6'b000010) and t+1 (vec 6'b100011), vbr=0x2001 -> expect pcload at t+1 and t+2 with pc=0x1000, then 0x1006.
5. dbgon asserted while in RESET, done also high -> expect pcload=0 and IDLE next cycle.
6. With CT_IFU_VECTOR_NMI_EN, nmi and expt_vld in the same IDLE cycle, nmivbr=0x3000 -> expect pc=0x1800. NMI during RESET -> expect serviced on the first IDLE cycle.
